symbol_timing_loop: RTL and testbench

Closes the symbol-timing recovery loop around gardner_ted_qam: consumes its timing-error samples through a valid/ready handshake and generates the per-symbol trigger strobe the detector uses.
- Proportional-integral (PI) loop filter followed by a modulo-1 decrementing NCO clocked by input-sample strobes.
- Sits between gardner_ted_qam (error source and trigger sink) and the downstream symbol decision logic (trigger sink).

---
 rtl/timing_loop_pkg.sv | 45 ++++
 rtl/pi_loop_filter.sv | 53 +++++
 rtl/symbol_timing_loop.sv | 154 +++++++++++++++
 tb/tb_symbol_timing_loop.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timing_loop_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timing_loop_pkg
// Purpose  : Shared types and helpers for the symbol-timing loop: the error
//            handshake state encoding, signed saturation / range clamping on
//            a wide intermediate type, and the nominal NCO step.
// Revision : 1.0 - initial release
// ============================================================================
package timing_loop_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCEPT = 2'd2
  } loop_state_e;

  // Nominal NCO decrement: one modulo-1 wrap every samples_per_symbol samples.
  function automatic int unsigned nominal_step(input int unsigned phase_bits,
                                               input int unsigned samples_per_symbol);
    return (32'd1 << phase_bits) / samples_per_symbol;
  endfunction

  // Clamp a wide signed value into the signed range of a width-bit word.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int unsigned width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

  // Clamp a wide signed value into [lo, hi].
  function automatic logic signed [63:0] clamp_range(input logic signed [63:0] value,
                                                     input logic signed [63:0] lo,
                                                     input logic signed [63:0] hi);
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pi_loop_filter.sv
`default_nettype none
// ============================================================================
// Module   : pi_loop_filter
// Purpose  : Proportional-integral loop filter with power-of-two gains.
//            On strobe, the integrator absorbs error >>> KiShift and the
//            output becomes (error >>> KpShift) + new integrator, both
//            saturated to AccumLengthBits signed.
// Revision : 1.0 - initial release
// ============================================================================
module pi_loop_filter
  import timing_loop_pkg::*;
#(
  parameter int ErrorLengthBits = 26,
  parameter int AccumLengthBits = 32,
  parameter int KpShift         = 8,
  parameter int KiShift         = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic signed [ErrorLengthBits-1:0] error,
  input  logic                              strobe,
  output logic signed [AccumLengthBits-1:0] filt,
  output logic signed [AccumLengthBits-1:0] integ
);

  logic signed [63:0] err_ext;
  logic signed [63:0] integ_ext;
  logic signed [63:0] integ_sum;
  logic signed [63:0] integ_next;
  logic signed [63:0] filt_sum;

  // Wide arithmetic so neither sum can wrap before saturation.
  always_comb begin
    err_ext    = {{(64-ErrorLengthBits){error[ErrorLengthBits-1]}}, error};
    integ_ext  = {{(64-AccumLengthBits){integ[AccumLengthBits-1]}}, integ};
    integ_sum  = integ_ext + (err_ext >>> KiShift);
    integ_next = sat_signed(integ_sum, AccumLengthBits);
    filt_sum   = (err_ext >>> KpShift) + integ_next;
  end

  // Integrator and filter output update only on an accepted error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      integ <= '0;
      filt  <= '0;
    end else if (strobe) begin
      integ <= AccumLengthBits'(integ_next);
      filt  <= AccumLengthBits'(sat_signed(filt_sum, AccumLengthBits));
    end
  end

endmodule
`default_nettype wire

// File: rtl/symbol_timing_loop.sv
`default_nettype none
// ============================================================================
// Module   : symbol_timing_loop
// Purpose  : Symbol-timing recovery loop. A modulo-1 decrementing NCO,
//            advanced by input-sample strobes, emits the per-symbol trigger;
//            a small FSM collects one timing error per symbol through a
//            valid/ready handshake and a PI filter steers the NCO step.
// Revision : 1.0 - initial release
// ============================================================================
module symbol_timing_loop
  import timing_loop_pkg::*;
#(
  parameter int SamplesPerSymbol = 4,
  parameter int ErrorLengthBits  = 26,
  parameter int PhaseLengthBits  = 16,
  parameter int AccumLengthBits  = 32,
  parameter int KpShift          = 8,
  parameter int KiShift          = 16,
  parameter int ErrorLatency     = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sample_valid,
  input  logic signed [ErrorLengthBits-1:0] error,
  input  logic                              error_valid,
  output logic                              error_ready,
  output logic                              trigger,
  output logic [PhaseLengthBits-1:0]        step,
  output logic                              missed_error
);

  localparam logic [PhaseLengthBits-1:0] NominalStep =
    PhaseLengthBits'(nominal_step(PhaseLengthBits, SamplesPerSymbol));
  localparam logic signed [63:0] StepMax = (64'sd1 <<< PhaseLengthBits) - 64'sd1;
  // The trigger edge itself is the first elapsed clock of the latency, so
  // the counter is loaded with what remains; a latency of one skips WAIT.
  localparam logic [3:0]   WaitLoad     = 4'(ErrorLatency - 1);
  localparam loop_state_e  TriggerState = (ErrorLatency == 1) ? ACCEPT : WAIT;

  logic [PhaseLengthBits-1:0]        phase;
  loop_state_e                       state;
  loop_state_e                       state_next;
  logic [3:0]                        wait_cnt;
  logic [3:0]                        wait_cnt_next;
  logic                              accept;
  logic                              miss_set;
  logic                              step_pending;
  logic signed [AccumLengthBits-1:0] filt;
  logic signed [AccumLengthBits-1:0] integ;
  logic signed [63:0]                step_target;

  assign trigger     = sample_valid && (phase < step);
  assign error_ready = (state == ACCEPT);
  assign accept      = error_ready && error_valid;

  pi_loop_filter #(
    .ErrorLengthBits (ErrorLengthBits),
    .AccumLengthBits (AccumLengthBits),
    .KpShift         (KpShift),
    .KiShift         (KiShift)
  ) u_filter (
    .clk    (clk),
    .rst    (rst),
    .error  (error),
    .strobe (accept),
    .filt   (filt),
    .integ  (integ)
  );

  // NCO phase: wraps modulo 2^PhaseLengthBits, advances only on samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '1;
    end else if (sample_valid) begin
      phase <= phase - step;
    end
  end

  // Candidate step: nominal plus filter correction, in wide signed math.
  always_comb begin
    step_target = {{(64-PhaseLengthBits){1'b0}}, NominalStep}
                + {{(64-AccumLengthBits){filt[AccumLengthBits-1]}}, filt};
  end

  // Step follows the filter one clock after it updates; never 0, never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step         <= NominalStep;
      step_pending <= 1'b0;
    end else begin
      step_pending <= accept;
      if (step_pending) begin
        step <= PhaseLengthBits'(clamp_range(step_target, 64'sd1, StepMax));
      end
    end
  end

  // Error handshake state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Next state: a trigger always (re)starts the wait, and counts as a miss
  // unless the pending error is being accepted in that same cycle.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    miss_set      = 1'b0;
    case (state)
      IDLE: begin
        state_next = IDLE;
      end
      WAIT: begin
        if (wait_cnt <= 4'd1) begin
          wait_cnt_next = '0;
          state_next    = ACCEPT;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
        end
      end
      ACCEPT: begin
        if (error_valid) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (trigger) begin
      miss_set      = (state != IDLE) && !accept;
      state_next    = TriggerState;
      wait_cnt_next = WaitLoad;
    end
  end

  // Sticky missed-error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      missed_error <= 1'b0;
    end else if (miss_set) begin
      missed_error <= 1'b1;
    end
  end

  // The integrator only moves on the clock that follows a handshake.
  assert property (@(posedge clk) disable iff (rst) !step_pending |-> $stable(integ));

endmodule
`default_nettype wire

// File: tb/tb_symbol_timing_loop.sv
`default_nettype none
// ============================================================================
// Module   : tb_symbol_timing_loop
// Purpose  : Self-checking bench for symbol_timing_loop: a behavioural model
//            feeds a scoreboard every cycle, plus vector rows and directed
//            sequences for latency, saturation and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_symbol_timing_loop;

  localparam int     LAT  = 2;
  localparam int     NOM  = 16384;
  localparam longint AMAX = 64'sd2147483647;
  localparam longint AMIN = -64'sd2147483648;
  localparam longint EMAX = 64'sd33554431;
  localparam longint EMIN = -64'sd33554432;

  logic               clk;
  logic               rst;
  logic               sample_valid;
  logic signed [25:0] error;
  logic               error_valid;
  logic               error_ready;
  logic               trigger;
  logic [15:0]        step;
  logic               missed_error;

  symbol_timing_loop dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .error        (error),
    .error_valid  (error_valid),
    .error_ready  (error_ready),
    .trigger      (trigger),
    .step         (step),
    .missed_error (missed_error)
  );

  typedef struct {
    bit trig;
    bit ready;
    int step;
    bit missed;
  } exp_t;

  typedef struct {
    string  name;
    int     period;
    bit     ev;
    longint err;
    int     cycles;
    int     exp_trig;
    int     exp_acc;
    int     exp_step;
    bit     exp_missed;
  } row_t;

  exp_t q[$];
  exp_t mon_e;
  row_t rows[3];

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int     m_phase, m_step, m_age;
  longint m_integ, m_filt;
  bit     m_pending, m_missed, m_pstep;

  // Observations from the latest drive cycle
  bit obs_trig, obs_ready, obs_missed;
  int obs_step;
  bit last_acc, last_trig_ready;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint satl(input longint v);
    if (v > AMAX) return AMAX;
    if (v < AMIN) return AMIN;
    return v;
  endfunction

  task automatic model_reset();
    m_phase = 65535; m_step = NOM; m_age = 0;
    m_integ = 0; m_filt = 0;
    m_pending = 0; m_missed = 0; m_pstep = 0;
  endtask

  // One clock: drive inputs, push the model's prediction, advance the model.
  task automatic drive(input bit sv, input bit ev, input longint e);
    exp_t   x;
    bit     m_trig, m_ready, m_acc;
    longint cand;
    @(posedge clk);
    #1;
    sample_valid = sv;
    error_valid  = ev;
    error        = e[25:0];
    m_trig  = sv && (m_phase < m_step);
    m_ready = m_pending && (m_age >= LAT);
    m_acc   = m_ready && ev;
    x.trig = m_trig; x.ready = m_ready; x.step = m_step; x.missed = m_missed;
    q.push_back(x);
    last_acc        = m_acc;
    last_trig_ready = m_trig && m_ready;
    #1;
    obs_trig   = trigger;
    obs_ready  = error_ready;
    obs_step   = int'(step);
    obs_missed = missed_error;
    if (sv) m_phase = (m_phase - m_step) & 65535;
    if (m_pstep) begin
      cand = 64'(NOM) + m_filt;
      if (cand < 1) cand = 1;
      if (cand > 65535) cand = 65535;
      m_step = int'(cand);
    end
    m_pstep = m_acc;
    if (m_acc) begin
      m_integ = satl(m_integ + (e >>> 16));
      m_filt  = satl((e >>> 8) + m_integ);
    end
    if (m_trig) begin
      if (m_pending && !m_acc) m_missed = 1;
      m_pending = 1;
      m_age     = 1;
    end else if (m_acc) begin
      m_pending = 0;
    end else if (m_pending && m_age < LAT) begin
      m_age++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_valid = 1'b0; error_valid = 1'b0; error = '0;
    repeat (2) @(posedge clk);
    q.delete();
    model_reset();
    #1;
    check("reset_step", step, NOM);
    check("reset_ready", error_ready, 0);
    check("reset_trigger", trigger, 0);
    check("reset_missed", missed_error, 0);
    rst = 1'b0;
  endtask

  // Scoreboard: compare the DUT mid-cycle against the queued prediction.
  always @(negedge clk) begin
    if (!rst && q.size() > 0) begin
      mon_e = q.pop_front();
      check("sb_trigger", trigger, mon_e.trig);
      check("sb_ready", error_ready, mon_e.ready);
      check("sb_step", step, mon_e.step);
      check("sb_missed", missed_error, mon_e.missed);
    end
  end

  initial begin
    int n, ntrig, nacc, last_t, first_idx;
    bit prev_ready;

    rst = 1'b1;
    sample_valid = 1'b0; error_valid = 1'b0; error = '0;
    model_reset();

    rows[0] = '{"t1_no_error",  1, 1'b0, 0, 16, 4,  0, 16384, 1'b1};
    rows[1] = '{"t2_zero_err",  1, 1'b1, 0, 40, 10, 9, 16384, 1'b0};
    rows[2] = '{"t5_sv_toggle", 2, 1'b1, 0, 40, 5,  4, 16384, 1'b0};

    foreach (rows[r]) begin
      do_reset();
      ntrig = 0; nacc = 0; last_t = -100; prev_ready = 0;
      for (int i = 1; i <= rows[r].cycles; i++) begin
        drive(((i - 1) % rows[r].period) == 0, rows[r].ev, rows[r].err);
        if (obs_ready && !prev_ready)
          check($sformatf("%s_ready_latency", rows[r].name), i - last_t, LAT);
        if (obs_trig) begin
          ntrig++;
          last_t = i;
        end
        if (obs_ready && rows[r].ev) nacc++;
        prev_ready = obs_ready;
      end
      check($sformatf("%s_triggers", rows[r].name), ntrig, rows[r].exp_trig);
      check($sformatf("%s_accepts", rows[r].name), nacc, rows[r].exp_acc);
      check($sformatf("%s_step", rows[r].name), obs_step, rows[r].exp_step);
      check($sformatf("%s_missed", rows[r].name), obs_missed, rows[r].exp_missed);
    end

    // Single error of 2^16: step moves exactly two clocks after the handshake.
    do_reset();
    n = 0; last_acc = 0;
    while (!last_acc && n < 40) begin drive(1, 1, 65536); n++; end
    check("t3_accept_seen", last_acc, 1);
    drive(1, 0, 0);
    check("t3_step_after_1clk", obs_step, 16384);
    drive(1, 0, 0);
    check("t3_step_after_2clk", obs_step, 16641);
    repeat (40) drive(1, 1, 0);
    check("t3_step_integ_hold", obs_step, 16385);
    check("t3_missed", obs_missed, 0);

    // Extreme errors: step pins at the top, then at one.
    do_reset();
    for (int i = 0; i < 80; i++) drive((i % 4) == 0, 1, EMAX);
    check("t4_step_max", obs_step, 65535);
    ntrig = 0;
    for (int i = 0; i < 32; i++) begin
      drive((i % 4) == 0, 1, EMAX);
      if (obs_trig) ntrig++;
    end
    check("t4_trigger_every_sample", ntrig, 8);
    for (int i = 0; i < 40; i++) drive((i % 4) == 0, 1, EMIN);
    check("t4_step_min", obs_step, 1);
    for (int i = 0; i < 40; i++) drive((i % 4) == 0, 1, EMIN);
    check("t4_step_min_hold", obs_step, 1);

    // Asynchronous reset while in ACCEPT with a trigger present.
    do_reset();
    n = 0; last_acc = 0;
    while (!last_acc && n < 40) begin drive(1, 1, 65536); n++; end
    check("t6_accept_seen", last_acc, 1);
    n = 0; last_trig_ready = 0;
    while (!last_trig_ready && n < 40) begin drive(1, 0, 0); n++; end
    check("t6_pre_reset_trigger", obs_trig, 1);
    check("t6_pre_reset_ready", obs_ready, 1);
    #1 rst = 1'b1;
    #1;
    check("t6_async_trigger", trigger, 0);
    check("t6_async_ready", error_ready, 0);
    do_reset();
    first_idx = 0;
    for (int i = 1; i <= 8; i++) begin
      drive(1, 0, 0);
      if (obs_trig && first_idx == 0) first_idx = i;
    end
    check("t6_first_trigger_idx", first_idx, 4);
    repeat (12) drive(1, 1, 0);
    check("t6_step_integ_cleared", obs_step, 16384);

    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
